// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pkg
// Brief    : Response codes and types shared by the AXI4-Lite blocks.
// Revision : 1.0
// ============================================================================
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_ram_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axil_ram_rd_fifo
// Brief    : Synchronous FIFO with registered storage, head visible on pop_data.
// Revision : 1.0
// ============================================================================
module axil_ram_rd_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 2,
  localparam int c_PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int c_CW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [c_CW-1:0]  count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wp;
  logic [c_PW-1:0]  r_rp;
  logic [c_CW-1:0]  r_cnt;
  logic             w_pop;

  // The owner bounds outstanding pushes, so only an empty pop needs guarding.
  assign w_pop = pop & (r_cnt != '0);

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push)  r_wp <= f_next(r_wp);
      if (w_pop) r_rp <= f_next(r_rp);
      if (push && !w_pop)      r_cnt <= r_cnt + c_CW'(1);
      else if (!push && w_pop) r_cnt <= r_cnt - c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= push_data;
  end

  assign pop_data = r_mem[r_rp];
  assign count    = r_cnt;

endmodule : axil_ram_rd_fifo
`default_nettype wire

// File: rtl/axil_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : axil_ram_pipe
// Brief    : AXI4-Lite slave RAM, independent AW/W capture, pipelined reads.
// Revision : 1.0
// ============================================================================
module axil_ram_pipe
  import axil_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int STRB_W = DW / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [DW-1:0]     s_axil_wdata,
  input  logic [STRB_W-1:0] s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [AW-1:0]     s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [DW-1:0]     s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready
);

  localparam int c_OFF = $clog2(STRB_W);
  localparam int c_IW  = AW - c_OFF;
  localparam int c_MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_FD  = RD_LAT + 1;
  localparam int c_OW  = $clog2(RD_LAT + 2);
  localparam int c_CW  = $clog2(c_FD + 1);
  localparam int c_RW  = DW + 2;

  logic [DW-1:0] r_mem [DEPTH] = '{default: '0};

  // Readies stay low for one extra cycle after reset is released.
  logic r_en;
  logic w_en;

  always_ff @(posedge clk) begin
    if (rst) r_en <= 1'b0;
    else     r_en <= 1'b1;
  end

  assign w_en = r_en & ~rst;

  // ---------------------------------------------------------------- write
  logic              r_aw_held;
  logic              r_w_held;
  logic [AW-1:0]     r_awaddr;
  logic [DW-1:0]     r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_bvalid;
  axil_resp_t        r_bresp;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [AW-1:0]     w_waddr;
  logic [DW-1:0]     w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic [c_IW-1:0]   w_widx;
  logic              w_wr_ok;

  assign s_axil_awready = w_en & ~r_aw_held;
  assign s_axil_wready  = w_en & ~r_w_held;
  assign w_aw_hs        = s_axil_awvalid & s_axil_awready;
  assign w_w_hs         = s_axil_wvalid & s_axil_wready;
  assign w_commit       = ~rst & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)
                        & (~r_bvalid | s_axil_bready);

  assign w_waddr = r_aw_held ? r_awaddr : s_axil_awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : s_axil_wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : s_axil_wstrb;
  assign w_widx  = w_waddr[AW-1:c_OFF];
  assign w_wr_ok = (c_IW+1)'(w_widx) < (c_IW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_commit)     r_aw_held <= 1'b0;
      else if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_commit)     r_w_held  <= 1'b0;
      else if (w_w_hs)  r_w_held  <= 1'b1;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs && !w_commit) r_awaddr <= s_axil_awaddr;
    if (w_w_hs && !w_commit) begin
      r_wdata <= s_axil_wdata;
      r_wstrb <= s_axil_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wstrb[b]) r_mem[w_widx[c_MW-1:0]][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;

  // ----------------------------------------------------------------- read
  logic [c_OW-1:0] r_occ;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic [c_IW-1:0] w_ridx;
  logic            w_rd_ok;
  logic [c_RW-1:0] w_rd_word;
  logic            w_push;
  logic [c_RW-1:0] w_push_data;
  logic [c_RW-1:0] w_fifo_q;
  logic [c_CW-1:0] w_fifo_cnt;

  assign s_axil_arready = w_en & (r_occ < c_OW'(c_FD));
  assign w_ar_hs        = s_axil_arvalid & s_axil_arready;
  assign w_r_hs         = s_axil_rvalid & s_axil_rready;
  assign w_ridx         = s_axil_araddr[AW-1:c_OFF];
  assign w_rd_ok        = (c_IW+1)'(w_ridx) < (c_IW+1)'(DEPTH);

  // Sampled before this cycle's write lands, giving read-first behaviour.
  assign w_rd_word = w_rd_ok ? {RESP_OKAY, r_mem[w_ridx[c_MW-1:0]]}
                             : {RESP_SLVERR, {DW{1'b0}}};

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_push      = w_ar_hs;
      assign w_push_data = w_rd_word;
    end else begin : g_pipe
      logic [RD_LAT-2:0] r_pv;
      logic [c_RW-1:0]   r_pd [RD_LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_pv <= '0;
        end else begin
          r_pv[0] <= w_ar_hs;
          for (int i = 1; i < RD_LAT - 1; i++) r_pv[i] <= r_pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        r_pd[0] <= w_rd_word;
        for (int i = 1; i < RD_LAT - 1; i++) r_pd[i] <= r_pd[i-1];
      end

      assign w_push      = r_pv[RD_LAT-2];
      assign w_push_data = r_pd[RD_LAT-2];
    end
  endgenerate

  axil_ram_rd_fifo #(
    .WIDTH (c_RW),
    .DEPTH (c_FD)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_r_hs),
    .pop_data  (w_fifo_q),
    .count     (w_fifo_cnt)
  );

  // Occupancy covers in-flight reads plus buffered ones, so the FIFO never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else if (w_ar_hs && !w_r_hs) begin
      r_occ <= r_occ + c_OW'(1);
    end else if (!w_ar_hs && w_r_hs) begin
      r_occ <= r_occ - c_OW'(1);
    end
  end

  assign s_axil_rvalid = (w_fifo_cnt != '0);
  assign s_axil_rdata  = s_axil_rvalid ? w_fifo_q[DW-1:0] : '0;
  assign s_axil_rresp  = s_axil_rvalid ? w_fifo_q[c_RW-1:DW] : RESP_OKAY;

  logic w_unused;
  assign w_unused = ^{s_axil_awprot, s_axil_arprot, w_waddr, s_axil_araddr};

endmodule : axil_ram_pipe
`default_nettype wire

// File: tb/tb_axil_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_ram_pipe
// Brief    : Directed scoreboard bench for axil_ram_pipe (RD_LAT = 3).
// Revision : 1.0
// ============================================================================
module tb_axil_ram_pipe;
  import axil_pkg::*;

  localparam int DW     = 32;
  localparam int AW     = 16;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [15:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;

  always #5 clk = ~clk;

  axil_ram_pipe #(
    .DW     (DW),
    .AW     (AW),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [33:0] r_exp_q [$];
  logic [1:0]  b_exp_q [$];
  int          b_cyc_q [$];
  int          r_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_pat(input int i);
    return {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
  endfunction

  // Response monitor: handshakes are seen mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        b_cyc_q.push_back(cyc);
        chk("b_expected", 64'(b_exp_q.size() != 0), 1);
        if (b_exp_q.size() != 0) chk("bresp", bresp, b_exp_q.pop_front());
      end
      if (rvalid && rready) begin
        logic [33:0] e;
        r_cyc_q.push_back(cyc);
        chk("r_expected", 64'(r_exp_q.size() != 0), 1);
        if (r_exp_q.size() != 0) begin
          e = r_exp_q.pop_front();
          chk("rdata", rdata, e[31:0]);
          chk("rresp", rresp, e[33:32]);
        end
      end
    end
  end

  task automatic xfer(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [15:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [1:0] exp_b, input logic [15:0] ra,
                      input logic [31:0] exp_rd, input logic [1:0] exp_rr,
                      output int aw_c, output int w_c, output int ar_c);
    bit aw_p = do_aw;
    bit w_p  = do_w;
    bit ar_p = do_ar;
    int t    = 0;
    aw_c = -1; w_c = -1; ar_c = -1;
    awaddr = wa; wdata = wd; wstrb = ws; araddr = ra;
    awvalid = aw_p; wvalid = w_p; arvalid = ar_p;
    if (do_w) b_exp_q.push_back(exp_b);
    while ((aw_p || w_p || ar_p) && t < 50) begin
      @(negedge clk);
      if (aw_p && awready) begin aw_p = 1'b0; aw_c = cyc; end
      if (w_p && wready)   begin w_p  = 1'b0; w_c  = cyc; end
      if (ar_p && arready) begin
        ar_p = 1'b0; ar_c = cyc;
        r_exp_q.push_back({exp_rr, exp_rd});
      end
      @(posedge clk); #1;
      awvalid = aw_p; wvalid = w_p; arvalid = ar_p;
      t++;
    end
    chk("xfer_timeout", 64'(aw_p || w_p || ar_p), 0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] eb);
    int c0, c1, c2;
    xfer(1, 1, 0, a, d, s, eb, '0, '0, '0, c0, c1, c2);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er);
    int c0, c1, c2;
    xfer(0, 0, 1, '0, '0, '0, '0, a, ed, er, c0, c1, c2);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((r_exp_q.size() + b_exp_q.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 64'(r_exp_q.size() + b_exp_q.size()), 0);
  endtask

  task automatic reset_seq(input int hold);
    @(posedge clk); #1;
    rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    r_exp_q.delete(); b_exp_q.delete(); b_cyc_q.delete(); r_cyc_q.delete();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk("rst_hi_ready", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fall1_ready", {awready, wready, arready}, 3'b000);
    chk("rst_fall1_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_fall1_resp", {bresp, rresp}, 4'h0);
    chk("rst_fall1_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_fall2_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw_c, w_c, ar_c, ar0, n_hs;

    reset_seq(3);

    // AW first, W three cycles later; B follows the W handshake cycle.
    xfer(1, 0, 0, 16'h0010, '0, '0, '0, '0, '0, '0, aw_c, w_c, ar_c);
    @(posedge clk); #1;
    @(posedge clk); #1;
    xfer(0, 1, 0, '0, 32'hDEADBEEF, 4'hF, RESP_OKAY, '0, '0, '0, ar_c, w_c, ar0);
    chk("aw_w_gap", 64'(w_c - aw_c), 3);
    @(negedge clk);
    chk("b_after_commit", {bvalid, bresp}, {1'b1, RESP_OKAY});
    @(posedge clk); #1;
    rd(16'h0010, 32'hDEADBEEF, RESP_OKAY);
    wait_drain();

    // Byte strobes, and an all-zero strobe that must leave the word alone.
    wr(16'h0040, 32'hAAAAAAAA, 4'hF, RESP_OKAY);
    wr(16'h0040, 32'h11223344, 4'h5, RESP_OKAY);
    wait_drain();
    rd(16'h0040, 32'hAA22AA44, RESP_OKAY);
    wr(16'h0040, 32'hFFFFFFFF, 4'h0, RESP_OKAY);
    wait_drain();
    rd(16'h0040, 32'hAA22AA44, RESP_OKAY);
    wait_drain();

    // Range boundary: last word is fine, DEPTH*4 is an error and aliases nothing.
    wr(16'h0000, 32'h12345678, 4'hF, RESP_OKAY);
    wr(16'h0FFC, 32'hCAFEF00D, 4'hF, RESP_OKAY);
    wr(16'h1000, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
    wait_drain();
    rd(16'h0000, 32'h12345678, RESP_OKAY);
    rd(16'h0FFC, 32'hCAFEF00D, RESP_OKAY);
    rd(16'h1000, 32'h00000000, RESP_SLVERR);
    wait_drain();

    // Back-to-back writes with bready held high.
    b_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      awaddr = 16'(i * 4); wdata = f_pat(i); wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      b_exp_q.push_back(RESP_OKAY);
      @(negedge clk);
      chk("b2b_wr_ready", {awready, wready}, 2'b11);
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    wait_drain();
    chk("b2b_wr_count", 64'(b_cyc_q.size()), 16);
    if (b_cyc_q.size() == 16) chk("b2b_wr_span", 64'(b_cyc_q[15] - b_cyc_q[0]), 15);

    // Back-to-back reads with rready held high.
    r_cyc_q.delete();
    ar0 = -1;
    for (int i = 0; i < 16; i++) begin
      araddr = 16'(i * 4); arvalid = 1'b1;
      @(negedge clk);
      chk("b2b_rd_ready", arready, 1'b1);
      if (arready) begin
        if (i == 0) ar0 = cyc;
        r_exp_q.push_back({RESP_OKAY, f_pat(i)});
      end
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    wait_drain();
    chk("b2b_rd_count", 64'(r_cyc_q.size()), 16);
    if (r_cyc_q.size() == 16) begin
      chk("rd_latency", 64'(r_cyc_q[0] - ar0), RD_LAT);
      chk("b2b_rd_span", 64'(r_cyc_q[15] - r_cyc_q[0]), 15);
    end

    // Back-pressure: only RD_LAT+1 reads may be outstanding.
    rready = 1'b0;
    n_hs = 0;
    araddr = 16'h0000; arvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (arready) begin
        r_exp_q.push_back({RESP_OKAY, f_pat(n_hs)});
        n_hs++;
      end
      @(posedge clk); #1;
      araddr = 16'(n_hs * 4);
    end
    @(negedge clk);
    chk("bp_ar_count", 64'(n_hs), RD_LAT + 1);
    chk("bp_arready_low", arready, 1'b0);
    chk("bp_rvalid_held", rvalid, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    wait_drain();

    // Same-cycle read and write to one word: read-first.
    wr(16'h0020, 32'h00000001, 4'hF, RESP_OKAY);
    wait_drain();
    xfer(1, 1, 1, 16'h0020, 32'h00000002, 4'hF, RESP_OKAY,
         16'h0020, 32'h00000001, RESP_OKAY, aw_c, w_c, ar_c);
    chk("same_cycle_aw", 64'(aw_c - ar_c), 0);
    chk("same_cycle_w", 64'(w_c - ar_c), 0);
    rd(16'h0020, 32'h00000002, RESP_OKAY);
    wait_drain();

    // Reset in the middle of stalled traffic drops everything.
    bready = 1'b0; rready = 1'b0;
    awaddr = 16'h0080; wdata = 32'h0BADC0DE; wstrb = 4'hF; araddr = 16'h0080;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_pending", {bvalid, rvalid}, 2'b11);
    reset_seq(2);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_b", 64'(b_cyc_q.size()), 0);
    chk("post_rst_no_r", 64'(r_cyc_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_axil_ram_pipe
`default_nettype wire
